layer_priority_sched: RTL and testbench

Runtime-programmable priority scheduler for the VGA drawing layers. It sits where the fixed-priority object multiplexer sits today, between the per-object drawing units and the VGA output stage. Each layer's priority rank and enable state are updated through a valid/ready command port. Staged changes take effect only at a frame boundary, so priority never changes mid-frame. Each pixel is resolved through a 2-stage pipeline, and pixels with no active requester get the background/MIF colour.

---
 rtl/objects_pkg.sv | 38 +++
 rtl/layer_priority_resolve.sv | 39 +++
 rtl/layer_priority_sched.sv | 284 ++++++++++++++++++++++++++++
 tb/tb_layer_priority_sched.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/objects_pkg.sv
// ---------------------------------------------------------------------------
// objects_pkg
//   Shared types and constants for the VGA drawing-object blocks.
//   - cmd_op_t      : layer scheduler command opcodes
//   - sched_state_t : layer scheduler commit FSM states
//   - MAX_LAYERS    : upper bound on drawing layers (index fits in IDX_W bits)
//   - identity_ranks: default rank table, rank[i] = i
// ---------------------------------------------------------------------------
package objects_pkg;

    localparam int unsigned MAX_LAYERS = 8;
    localparam int unsigned IDX_W      = 3;

    typedef logic [IDX_W-1:0] lidx_t;
    typedef logic [MAX_LAYERS-1:0][IDX_W-1:0] rank_tbl_t;

    typedef enum logic [1:0] {
        SWAP         = 2'd0,
        ENABLE       = 2'd1,
        DISABLE      = 2'd2,
        BLINK_TOGGLE = 2'd3
    } cmd_op_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STAGED = 2'd1,
        COMMIT = 2'd2
    } sched_state_t;

    function automatic rank_tbl_t identity_ranks();
        rank_tbl_t t;
        for (int unsigned i = 0; i < MAX_LAYERS; i++) begin
            t[i] = lidx_t'(i);
        end
        return t;
    endfunction

endpackage

// File: rtl/layer_priority_resolve.sv
// ---------------------------------------------------------------------------
// layer_priority_resolve
//   Combinational winner search: among layers with req && en, pick the one
//   with the lowest rank. Ranks form a permutation, so there are no ties.
//   Ports:
//     req   in  NUM_LAYERS            per-layer drawing request
//     en    in  NUM_LAYERS            per-layer effective enable
//     rank  in  NUM_LAYERS x IDX_W    per-layer priority rank (0 = highest)
//     idx   out IDX_W                 winning layer index (0 when none)
//     valid out 1                     some layer is eligible
// ---------------------------------------------------------------------------
module layer_priority_resolve
    import objects_pkg::*;
#(
    parameter int unsigned NUM_LAYERS = 4
) (
    input  logic [NUM_LAYERS-1:0]            req,
    input  logic [NUM_LAYERS-1:0]            en,
    input  logic [NUM_LAYERS-1:0][IDX_W-1:0] rank,
    output logic [IDX_W-1:0]                 idx,
    output logic                             valid
);

    lidx_t best_rank;

    always_comb begin
        idx       = '0;
        valid     = 1'b0;
        best_rank = '1;
        for (int unsigned i = 0; i < NUM_LAYERS; i++) begin
            if (req[i] && en[i] && (!valid || (rank[i] < best_rank))) begin
                valid     = 1'b1;
                best_rank = rank[i];
                idx       = lidx_t'(i);
            end
        end
    end

endmodule

// File: rtl/layer_priority_sched.sv
// ---------------------------------------------------------------------------
// layer_priority_sched
//   Runtime-programmable priority multiplexer for the VGA drawing layers.
//   Commands edit shadow rank/enable tables; the shadow is copied to the
//   active tables in a one-cycle COMMIT state entered on startOfFrame, so
//   priority never changes mid-frame. Pixels resolve through a 2-stage
//   pipeline (inputs -> winner/colour regs -> output regs).
//
//   Optional feature: define LAYER_BLINK_EN for per-layer blink masks and a
//   (BLINK_SHIFT+1)-bit frame counter; blinking layers are hidden while the
//   counter MSB is set. Without it, BLINK_TOGGLE is an accepted no-op.
//
//   Ports:
//     clk, resetN         pixel clock, async active-low reset
//     startOfFrame        one-cycle pulse at first pixel of a frame
//     layerReq/layerRGB   per-layer request and colour (layer i at [i*RGB_W +: RGB_W])
//     fallbackRGB         colour used when no layer wins
//     cmdValid/cmdReady   command handshake; cmdReady depends on state only
//     cmdOp, cmdA, cmdB   opcode and layer indices (cmdB used by SWAP)
//     RGBOut, winnerIdx, winnerValid   resolved pixel, 2 cycles latency
//     pending             staged edits await a frame boundary
// ---------------------------------------------------------------------------
module layer_priority_sched
    import objects_pkg::*;
#(
    parameter int unsigned NUM_LAYERS  = 4,
    parameter int unsigned RGB_W       = 8,
    parameter int unsigned BLINK_SHIFT = 4
) (
    input  logic                        clk,
    input  logic                        resetN,
    input  logic                        startOfFrame,
    input  logic [NUM_LAYERS-1:0]       layerReq,
    input  logic [NUM_LAYERS*RGB_W-1:0] layerRGB,
    input  logic [RGB_W-1:0]            fallbackRGB,
    input  logic                        cmdValid,
    output logic                        cmdReady,
    input  logic [1:0]                  cmdOp,
    input  logic [2:0]                  cmdA,
    input  logic [2:0]                  cmdB,
    output logic [RGB_W-1:0]            RGBOut,
    output logic [2:0]                  winnerIdx,
    output logic                        winnerValid,
    output logic                        pending
);

    typedef logic [NUM_LAYERS-1:0][IDX_W-1:0] rank_arr_t;
    typedef logic [NUM_LAYERS-1:0][RGB_W-1:0] rgb_arr_t;

    localparam rank_tbl_t ID_ALL    = identity_ranks();
    localparam rank_arr_t RANK_RST  = ID_ALL[NUM_LAYERS-1:0];
    localparam lidx_t     LAST_IDX  = lidx_t'(NUM_LAYERS - 1);

    // Control state
    sched_state_t state_q, state_d;
    logic         pending_q, pending_d;

    // A command that arrives together with startOfFrame in STAGED is held
    // here and applied to the shadow during COMMIT, after the copy.
    logic         defer_vld_q, defer_vld_d;
    cmd_op_t      defer_op_q, defer_op_d;
    lidx_t        defer_a_q, defer_a_d;
    lidx_t        defer_b_q, defer_b_d;

    // Tables
    rank_arr_t             rank_act_q, rank_act_d;
    rank_arr_t             rank_sh_q, rank_sh_d;
    logic [NUM_LAYERS-1:0] en_act_q, en_act_d;
    logic [NUM_LAYERS-1:0] en_sh_q, en_sh_d;
`ifdef LAYER_BLINK_EN
    localparam int unsigned FCNT_W = BLINK_SHIFT + 1;
    logic [NUM_LAYERS-1:0] blink_act_q, blink_act_d;
    logic [NUM_LAYERS-1:0] blink_sh_q, blink_sh_d;
    logic [FCNT_W-1:0]     fcnt_q, fcnt_d;
`endif

    // Pipeline
    rgb_arr_t   rgb_s1_q, rgb_s1_d;
    logic [RGB_W-1:0] fb_s1_q, fb_s1_d;
    lidx_t      widx_s1_q, widx_s1_d;
    logic       wvld_s1_q, wvld_s1_d;
    logic [RGB_W-1:0] rgb_out_q, rgb_out_d;
    lidx_t      widx_out_q, widx_out_d;
    logic       wvld_out_q, wvld_out_d;

    // Shadow-edit source
    logic    cmd_fire;
    logic    sof_collide;
    logic    ed_vld;
    cmd_op_t ed_op;
    lidx_t   ed_a, ed_b;
    logic    a_ok, b_ok;
    lidx_t   rank_at_a, rank_at_b;

    logic [NUM_LAYERS-1:0] en_eff;
    lidx_t                 res_idx;
    logic                  res_vld;

    assign cmdReady = (state_q != COMMIT);

    // ---------------------------------------------------------------------
    // Command decode and shadow edit
    // ---------------------------------------------------------------------
    always_comb begin
        cmd_fire    = cmdValid && cmdReady;
        sof_collide = (state_q == STAGED) && startOfFrame && cmd_fire;

        // No live command can fire in COMMIT, so the deferred one owns the port.
        if (state_q == COMMIT) begin
            ed_vld = defer_vld_q;
            ed_op  = defer_op_q;
            ed_a   = defer_a_q;
            ed_b   = defer_b_q;
        end else begin
            ed_vld = cmd_fire && !sof_collide;
            ed_op  = cmd_op_t'(cmdOp);
            ed_a   = cmdA;
            ed_b   = cmdB;
        end

        a_ok = (ed_a <= LAST_IDX);
        b_ok = (ed_b <= LAST_IDX);

        rank_at_a = '0;
        rank_at_b = '0;
        for (int unsigned i = 0; i < NUM_LAYERS; i++) begin
            if (lidx_t'(i) == ed_a) rank_at_a = rank_sh_q[i];
            if (lidx_t'(i) == ed_b) rank_at_b = rank_sh_q[i];
        end

        rank_sh_d = rank_sh_q;
        en_sh_d   = en_sh_q;
`ifdef LAYER_BLINK_EN
        blink_sh_d = blink_sh_q;
`endif
        if (ed_vld && a_ok) begin
            for (int unsigned i = 0; i < NUM_LAYERS; i++) begin
                case (ed_op)
                    SWAP: begin
                        if (b_ok && (ed_a != ed_b)) begin
                            if (lidx_t'(i) == ed_a)      rank_sh_d[i] = rank_at_b;
                            else if (lidx_t'(i) == ed_b) rank_sh_d[i] = rank_at_a;
                        end
                    end
                    ENABLE:  if (lidx_t'(i) == ed_a) en_sh_d[i] = 1'b1;
                    DISABLE: if (lidx_t'(i) == ed_a) en_sh_d[i] = 1'b0;
                    BLINK_TOGGLE: begin
`ifdef LAYER_BLINK_EN
                        if (lidx_t'(i) == ed_a) blink_sh_d[i] = ~blink_sh_q[i];
`endif
                    end
                    default: ;
                endcase
            end
        end
    end

    // ---------------------------------------------------------------------
    // FSM next state, commit copy, deferred command capture
    // ---------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (cmd_fire) state_d = STAGED;
            STAGED:  if (startOfFrame) state_d = COMMIT;
            COMMIT:  state_d = defer_vld_q ? STAGED : IDLE;
            default: state_d = IDLE;
        endcase
        pending_d = (state_d == STAGED);

        defer_vld_d = sof_collide;
        defer_op_d  = cmd_op_t'(cmdOp);
        defer_a_d   = cmdA;
        defer_b_d   = cmdB;

        rank_act_d = rank_act_q;
        en_act_d   = en_act_q;
`ifdef LAYER_BLINK_EN
        blink_act_d = blink_act_q;
        fcnt_d      = startOfFrame ? fcnt_q + 1'b1 : fcnt_q;
`endif
        if (state_q == COMMIT) begin
            rank_act_d = rank_sh_q;
            en_act_d   = en_sh_q;
`ifdef LAYER_BLINK_EN
            blink_act_d = blink_sh_q;
`endif
        end
    end

    // ---------------------------------------------------------------------
    // Pixel pipeline
    // ---------------------------------------------------------------------
`ifdef LAYER_BLINK_EN
    assign en_eff = en_act_q & ~(blink_act_q & {NUM_LAYERS{fcnt_q[FCNT_W-1]}});
`else
    assign en_eff = en_act_q;
`endif

    layer_priority_resolve #(
        .NUM_LAYERS (NUM_LAYERS)
    ) u_resolve (
        .req   (layerReq),
        .en    (en_eff),
        .rank  (rank_act_q),
        .idx   (res_idx),
        .valid (res_vld)
    );

    always_comb begin
        rgb_s1_d  = layerRGB;
        fb_s1_d   = fallbackRGB;
        widx_s1_d = res_idx;
        wvld_s1_d = res_vld;

        rgb_out_d = fb_s1_q;
        if (wvld_s1_q) begin
            for (int unsigned i = 0; i < NUM_LAYERS; i++) begin
                if (lidx_t'(i) == widx_s1_q) rgb_out_d = rgb_s1_q[i];
            end
        end
        widx_out_d = wvld_s1_q ? widx_s1_q : '0;
        wvld_out_d = wvld_s1_q;
    end

    // ---------------------------------------------------------------------
    // Registers
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q     <= IDLE;
            pending_q   <= 1'b0;
            defer_vld_q <= 1'b0;
            defer_op_q  <= SWAP;
            defer_a_q   <= '0;
            defer_b_q   <= '0;
            rank_act_q  <= RANK_RST;
            rank_sh_q   <= RANK_RST;
            en_act_q    <= '1;
            en_sh_q     <= '1;
`ifdef LAYER_BLINK_EN
            blink_act_q <= '0;
            blink_sh_q  <= '0;
            fcnt_q      <= '0;
`endif
            rgb_s1_q    <= '0;
            fb_s1_q     <= '0;
            widx_s1_q   <= '0;
            wvld_s1_q   <= 1'b0;
            rgb_out_q   <= '0;
            widx_out_q  <= '0;
            wvld_out_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            pending_q   <= pending_d;
            defer_vld_q <= defer_vld_d;
            defer_op_q  <= defer_op_d;
            defer_a_q   <= defer_a_d;
            defer_b_q   <= defer_b_d;
            rank_act_q  <= rank_act_d;
            rank_sh_q   <= rank_sh_d;
            en_act_q    <= en_act_d;
            en_sh_q     <= en_sh_d;
`ifdef LAYER_BLINK_EN
            blink_act_q <= blink_act_d;
            blink_sh_q  <= blink_sh_d;
            fcnt_q      <= fcnt_d;
`endif
            rgb_s1_q    <= rgb_s1_d;
            fb_s1_q     <= fb_s1_d;
            widx_s1_q   <= widx_s1_d;
            wvld_s1_q   <= wvld_s1_d;
            rgb_out_q   <= rgb_out_d;
            widx_out_q  <= widx_out_d;
            wvld_out_q  <= wvld_out_d;
        end
    end

    assign RGBOut      = rgb_out_q;
    assign winnerIdx   = widx_out_q;
    assign winnerValid = wvld_out_q;
    assign pending     = pending_q;

endmodule

// File: tb/tb_layer_priority_sched.sv
module tb_layer_priority_sched;

    localparam logic [1:0] OP_SWAP  = 2'd0;
    localparam logic [1:0] OP_EN    = 2'd1;
    localparam logic [1:0] OP_DIS   = 2'd2;
    localparam logic [1:0] OP_BLINK = 2'd3;

    localparam logic [7:0] C0 = 8'h11;
    localparam logic [7:0] C1 = 8'h22;
    localparam logic [7:0] C2 = 8'h33;
    localparam logic [7:0] C3 = 8'h44;
    localparam logic [7:0] FB = 8'hF0;

    logic        clk = 1'b0;
    logic        resetN;
    logic        startOfFrame;
    logic [3:0]  layerReq;
    logic [31:0] layerRGB;
    logic [7:0]  fallbackRGB;
    logic        cmdValid;
    logic        cmdReady;
    logic [1:0]  cmdOp;
    logic [2:0]  cmdA;
    logic [2:0]  cmdB;
    logic [7:0]  RGBOut;
    logic [2:0]  winnerIdx;
    logic        winnerValid;
    logic        pending;

    int checks = 0;
    int errors = 0;
    int frames = 0;
    logic [7:0] exp_rgb;

    layer_priority_sched #(
        .NUM_LAYERS  (4),
        .RGB_W       (8),
        .BLINK_SHIFT (1)
    ) dut (
        .clk          (clk),
        .resetN       (resetN),
        .startOfFrame (startOfFrame),
        .layerReq     (layerReq),
        .layerRGB     (layerRGB),
        .fallbackRGB  (fallbackRGB),
        .cmdValid     (cmdValid),
        .cmdReady     (cmdReady),
        .cmdOp        (cmdOp),
        .cmdA         (cmdA),
        .cmdB         (cmdB),
        .RGBOut       (RGBOut),
        .winnerIdx    (winnerIdx),
        .winnerValid  (winnerValid),
        .pending      (pending)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic send_cmd(input logic [1:0] op, input logic [2:0] a, input logic [2:0] b);
        bit done;
        done     = 1'b0;
        cmdValid = 1'b1;
        cmdOp    = op;
        cmdA     = a;
        cmdB     = b;
        for (int n = 0; n < 10 && !done; n++) begin
            if (cmdReady) done = 1'b1;
            tick();
        end
        cmdValid = 1'b0;
        if (!done) check("cmd_accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic sof_pulse();
        startOfFrame = 1'b1;
        tick();
        startOfFrame = 1'b0;
        frames++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        resetN       = 1'b0;
        startOfFrame = 1'b0;
        layerReq     = 4'b0000;
        layerRGB     = {C3, C2, C1, C0};
        fallbackRGB  = FB;
        cmdValid     = 1'b0;
        cmdOp        = OP_SWAP;
        cmdA         = 3'd0;
        cmdB         = 3'd0;

        ticks(3);
        check("rst_rgb", 32'(RGBOut), 32'h0);
        check("rst_idx", 32'(winnerIdx), 32'd0);
        check("rst_vld", 32'(winnerValid), 32'd0);
        check("rst_pending", 32'(pending), 32'd0);
        check("rst_ready", 32'(cmdReady), 32'd1);

        // Basic resolve and exact 2-cycle latency
        resetN   = 1'b1;
        layerReq = 4'b0011;
        tick();
        check("lat1_rgb", 32'(RGBOut), 32'h0);
        tick();
        check("lat2_rgb", 32'(RGBOut), 32'(C0));
        check("lat2_idx", 32'(winnerIdx), 32'd0);
        check("lat2_vld", 32'(winnerValid), 32'd1);
        startOfFrame = 1'b1;                       // SOF in IDLE: no effect
        tick();
        startOfFrame = 1'b0;
        frames++;
        check("idle_sof_pending", 32'(pending), 32'd0);
        check("idle_sof_ready", 32'(cmdReady), 32'd1);

        // SWAP(0,1) staged mid-frame, takes effect after COMMIT
        send_cmd(OP_SWAP, 3'd0, 3'd1);
        check("swap_pending", 32'(pending), 32'd1);
        ticks(3);
        check("swap_staged_rgb", 32'(RGBOut), 32'(C0));
        check("swap_staged_pending", 32'(pending), 32'd1);
        sof_pulse();
        check("commit_ready", 32'(cmdReady), 32'd0);
        check("commit_pending", 32'(pending), 32'd0);
        ticks(2);
        check("commit_old_rgb", 32'(RGBOut), 32'(C0));
        tick();
        check("commit_new_rgb", 32'(RGBOut), 32'(C1));
        check("commit_new_idx", 32'(winnerIdx), 32'd1);
        check("commit_idle_ready", 32'(cmdReady), 32'd1);

        // DISABLE(0): only requester disabled -> fallback
        send_cmd(OP_DIS, 3'd0, 3'd0);
        sof_pulse();
        layerReq = 4'b0001;
        ticks(4);
        check("dis_rgb", 32'(RGBOut), 32'(FB));
        check("dis_vld", 32'(winnerValid), 32'd0);
        check("dis_idx", 32'(winnerIdx), 32'd0);

        // Command colliding with SOF lands after the commit
        send_cmd(OP_EN, 3'd0, 3'd0);
        startOfFrame = 1'b1;
        cmdValid     = 1'b1;
        cmdOp        = OP_SWAP;
        cmdA         = 3'd0;
        cmdB         = 3'd1;
        tick();
        startOfFrame = 1'b0;
        cmdValid     = 1'b0;
        frames++;
        check("coll_commit_ready", 32'(cmdReady), 32'd0);
        check("coll_commit_pending", 32'(pending), 32'd0);
        tick();
        check("coll_after_pending", 32'(pending), 32'd1);
        layerReq = 4'b0011;
        ticks(3);
        check("coll_rgb", 32'(RGBOut), 32'(C1));
        check("coll_idx", 32'(winnerIdx), 32'd1);
        sof_pulse();
        ticks(4);
        check("coll2_rgb", 32'(RGBOut), 32'(C0));
        check("coll2_idx", 32'(winnerIdx), 32'd0);
        check("coll2_pending", 32'(pending), 32'd0);

        // Degenerate commands: accepted, ranks unchanged
        send_cmd(OP_SWAP, 3'd2, 3'd7);
        check("degen_pending", 32'(pending), 32'd1);
        send_cmd(OP_SWAP, 3'd1, 3'd1);
        send_cmd(OP_DIS, 3'd6, 3'd0);
        sof_pulse();
        layerReq = 4'b1111;
        ticks(4);
        check("degen_1111_rgb", 32'(RGBOut), 32'(C0));
        layerReq = 4'b1110;
        ticks(2);
        check("degen_1110_rgb", 32'(RGBOut), 32'(C1));
        check("degen_1110_idx", 32'(winnerIdx), 32'd1);
        layerReq = 4'b1100;
        ticks(2);
        check("degen_1100_rgb", 32'(RGBOut), 32'(C2));
        check("degen_1100_idx", 32'(winnerIdx), 32'd2);
        layerReq = 4'b1000;
        ticks(2);
        check("degen_1000_rgb", 32'(RGBOut), 32'(C3));
        check("degen_1000_idx", 32'(winnerIdx), 32'd3);

        // Blink toggle on layer 0
        send_cmd(OP_BLINK, 3'd0, 3'd0);
        check("blink_pending", 32'(pending), 32'd1);
        sof_pulse();
        layerReq = 4'b0001;
        for (int f = 0; f < 6; f++) begin
            sof_pulse();
            ticks(4);
`ifdef LAYER_BLINK_EN
            exp_rgb = frames[1] ? FB : C0;
`else
            exp_rgb = C0;
`endif
            check($sformatf("blink_f%0d", f), 32'(RGBOut), 32'(exp_rgb));
        end

        // Asynchronous reset while STAGED discards staged edits
        send_cmd(OP_DIS, 3'd0, 3'd0);
        check("prerst_pending", 32'(pending), 32'd1);
        #2;
        resetN = 1'b0;
        #1;
        check("arst_pending", 32'(pending), 32'd0);
        check("arst_rgb", 32'(RGBOut), 32'h0);
        frames = 0;
        tick();
        resetN   = 1'b1;
        layerReq = 4'b0011;
        sof_pulse();
        ticks(4);
        check("postrst_rgb", 32'(RGBOut), 32'(C0));
        check("postrst_idx", 32'(winnerIdx), 32'd0);
        check("postrst_pending", 32'(pending), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
